gpr_file_mp: RTL
================

# gpr_file_mp

Parametrised multi-read-port general-purpose register file with a per-register pending-write scoreboard, successor to the fixed 32x32, 2-read-port GPR. Sits in the decode/writeback stages of the pipelined core: decode reads operands and checks hazards, issue marks destinations busy, and writeback commits results and clears busy bits. Register 0 is hard-wired to zero. Stack and global pointer reset values are parameters.

## Interface
- DW, 32: data width in bits
- AW, 5: address width; depth = 2^AW registers
- NRD, 2: number of read ports (1..4)
- SP_IDX, 29: stack-pointer register index
- SP_INIT, 32'h00002ffc: SP reset value (DW bits)
- GP_IDX, 28: global-pointer register index
- GP_INIT, 32'h00001800: GP reset value (DW bits)

- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- rd_adr  in  NRD*AW  read addresses; port k uses bits [k*AW +: AW]
- rd_data  out  NRD*DW  read data; port k uses bits [k*DW +: DW]; combinational
- rd_busy  out  NRD  1 = the register addressed by port k has a pending write
- wr_en  in  1  writeback commit strobe
- wr_adr  in  AW  writeback destination
- wr_data  in  DW  writeback data
- iss_en  in  1  issue strobe; marks iss_adr busy
- iss_adr  in  AW  issued destination register

## Operation
- Storage: 2^AW x DW registers (reg[0] not stored or always zero) plus a busy[2^AW-1:0] vector.
- Reset (rst=1 at edge): every reg = 0, except reg[SP_IDX]=SP_INIT and reg[GP_IDX]=GP_INIT. All busy bits = 0. Reset overrides a wr_en or iss_en in the same cycle.
- Write: wr_en=1 and wr_adr!=0 -> reg[wr_adr] <= wr_data and busy[wr_adr] <= 0 at the edge. wr_adr=0 is ignored (no state change).
- Issue: iss_en=1 and iss_adr!=0 -> busy[iss_adr] <= 1. iss_adr=0 is ignored.
- Same-edge issue and write to the same register: data is written, and busy ends at 1 because the newer producer wins. Different registers: both take effect.
- Read port k: rd_adr_k==0 -> rd_data_k=0 and rd_busy_k=0. Otherwise rd_data_k = reg[rd_adr_k] and rd_busy_k = busy[rd_adr_k], subject to the bypass described under Configuration.
- Read ports are independent. Any number of ports may address the same register.
- Outputs during/after reset: rd_data reflects the reset contents (0, SP_INIT or GP_INIT by address). rd_busy is all 0.

## Timing
- Read: zero-latency combinational from rd_adr (and, with bypass, from wr_*).
- Write and issue: one cycle. State is visible to the non-bypassed read path in the cycle after the edge.
- No back-pressure: wr_en and iss_en are accepted every cycle unconditionally.
- Busy lifetime: set at the issue edge. Cleared at the edge of the matching write, unless the same-edge issue rule applies.

## Configuration
- GPR_BYPASS_EN defined: write-to-read forwarding is compiled in. When wr_en=1, wr_adr!=0 and rd_adr_k==wr_adr, then rd_data_k=wr_data and rd_busy_k=0 in the same cycle. This holds even if iss_en targets the same register in that cycle, because the issue takes effect next cycle.
- GPR_BYPASS_EN undefined: no forwarding. Same-cycle reads return the old contents and old busy bit. The new value is seen one cycle later.

## Test plan
- Reset, then read 29, 28, 5, 0 -> 0x00002ffc, 0x00001800, 0, 0; all rd_busy 0.
- Write 0xDEADBEEF to r0, then read r0 -> 0; r0 is never busy, even after iss_en with iss_adr=0.
- iss r7, then next cycle read r7 -> busy=1. Write r7=0x12345678 -> busy=0 and data 0x12345678 next cycle. With GPR_BYPASS_EN, the value and busy=0 are visible in the write cycle.
- Same edge: iss r9 and write r9=0xA5 -> r9 holds 0xA5 and busy=1. A later write r9=0x5A clears busy.
- NRD=4, all ports read r3 while r3 is written with 0xCAFE -> all ports show old data (bypass off) or 0xCAFE (bypass on).
- rst asserted together with write r29=0x1 and iss r29 -> r29=0x00002ffc and busy=0.

Source files
------------

// File: rtl/gpr_file_mp.sv
// -----------------------------------------------------------------------------
// gpr_file_mp
//
// Parametrised general-purpose register file with NRD independent read ports
// and a per-register pending-write (busy) scoreboard. Decode reads operands and
// hazard bits, issue marks a destination busy, writeback commits data and
// clears the busy bit. Register 0 always reads as zero and is never busy.
//
// Optional feature (compile-time macro):
//   GPR_BYPASS_EN  - forward the writeback port to matching read ports in the
//                    same cycle (data = wr_data_i, busy = 0).
//
// Ports:
//   clk        in   clock, all state updates on the rising edge
//   rst        in   synchronous active-high reset
//   rd_adr_i   in   NRD*AW read addresses, port k at [k*AW +: AW]
//   rd_data_o  out  NRD*DW read data, port k at [k*DW +: DW] (combinational)
//   rd_busy_o  out  NRD pending-write flags, one per read port
//   wr_en_i    in   writeback commit strobe
//   wr_adr_i   in   writeback destination register
//   wr_data_i  in   writeback data
//   iss_en_i   in   issue strobe, marks iss_adr_i busy
//   iss_adr_i  in   issued destination register
// -----------------------------------------------------------------------------
module gpr_file_mp #(
  parameter int unsigned         DW      = 32,
  parameter int unsigned         AW      = 5,
  parameter int unsigned         NRD     = 2,
  parameter int unsigned         SP_IDX  = 29,
  parameter logic [DW-1:0]       SP_INIT = 32'h00002ffc,
  parameter int unsigned         GP_IDX  = 28,
  parameter logic [DW-1:0]       GP_INIT = 32'h00001800
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD*AW-1:0]   rd_adr_i,
  output logic [NRD*DW-1:0]   rd_data_o,
  output logic [NRD-1:0]      rd_busy_o,
  input  logic                wr_en_i,
  input  logic [AW-1:0]       wr_adr_i,
  input  logic [DW-1:0]       wr_data_i,
  input  logic                iss_en_i,
  input  logic [AW-1:0]       iss_adr_i
);

  localparam int unsigned DEPTH = 1 << AW;

  // Entry 0 exists in the array for uniform indexing but is never written,
  // and the read path forces it to zero regardless.
  logic [DW-1:0]    regs_q [DEPTH];
  logic [DW-1:0]    regs_d [DEPTH];
  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;

  logic wr_hit;
  logic iss_hit;

  assign wr_hit  = wr_en_i  && (wr_adr_i  != '0);
  assign iss_hit = iss_en_i && (iss_adr_i != '0);

  function automatic logic [DW-1:0] reset_value(input int unsigned idx);
    if (idx == SP_IDX)      return SP_INIT;
    else if (idx == GP_IDX) return GP_INIT;
    else                    return '0;
  endfunction

  // ---------------------------------------------------------------------------
  // Next-state: write first, then issue, so a same-edge issue to the register
  // being written leaves it busy (the newer producer wins).
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every target gets its hold value before any condition, so no path
    // through this block leaves a variable unassigned and no latch is inferred.
    regs_d = regs_q;
    busy_d = busy_q;
    if (wr_hit) begin
      regs_d[wr_adr_i] = wr_data_i;
      busy_d[wr_adr_i] = 1'b0;
    end
    if (iss_hit) begin
      busy_d[iss_adr_i] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the whole array is reset on purpose: SP and GP carry architectural
      // reset values and software relies on the rest reading as zero, so this
      // storage cannot be left uninitialised like a plain data RAM.
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= reset_value(i);
      end
      busy_q <= '0;
    end else begin
      // NOTE: non-blocking assignments for all state so every register samples
      // the pre-edge values, independent of statement order.
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Read ports: independent combinational muxes.
  // ---------------------------------------------------------------------------
  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0] adr;
    logic [DW-1:0] data;
    logic          busy;

    assign adr = rd_adr_i[k*AW +: AW];

    always_comb begin
      data = regs_q[adr];
      busy = busy_q[adr];
`ifdef GPR_BYPASS_EN
      // A same-cycle issue to this register only lands next cycle, so the
      // forwarded value is reported not busy.
      if (wr_hit && (adr == wr_adr_i)) begin
        data = wr_data_i;
        busy = 1'b0;
      end
`endif
      if (adr == '0) begin
        data = '0;
        busy = 1'b0;
      end
    end

    assign rd_data_o[k*DW +: DW] = data;
    assign rd_busy_o[k]          = busy;
  end

endmodule
